// File: rtl/ysyx_22050612_mem_arbiter.sv
// Round-robin arbiter between the IFU and LSU for the single shared memory port.
// One transaction is outstanding at a time: grant in IDLE, issue in REQ, collect in RESP.
module ysyx_22050612_mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_req_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_resp_data,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic                lsu_req_wen,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_resp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data
);

  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;
  typedef enum logic {GRANT_IFU = 1'b0, GRANT_LSU = 1'b1} grant_e;

  state_e              state_q, state_d;
  grant_e              last_grant_q, last_grant_d;
  grant_e              grant_id_q, grant_id_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic                ifu_resp_valid_q, ifu_resp_valid_d;
  logic                lsu_resp_valid_q, lsu_resp_valid_d;
  logic [DATA_W-1:0]   ifu_resp_data_q, ifu_resp_data_d;
  logic [DATA_W-1:0]   lsu_resp_data_q, lsu_resp_data_d;
  logic                grant_ifu, grant_lsu;
  logic [DATA_W-1:0]   resp_data;

  // Writes are acknowledged with zero data so the LSU never sees stale bus contents.
  assign resp_data = wen_q ? '0 : mem_resp_data;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d          = state_q;
    last_grant_d     = last_grant_q;
    grant_id_d       = grant_id_q;
    addr_d           = addr_q;
    wen_d            = wen_q;
    wdata_d          = wdata_q;
    wmask_d          = wmask_q;
    ifu_resp_valid_d = 1'b0;
    lsu_resp_valid_d = 1'b0;
    ifu_resp_data_d  = ifu_resp_data_q;
    lsu_resp_data_d  = lsu_resp_data_q;
    grant_ifu        = 1'b0;
    grant_lsu        = 1'b0;

    unique case (state_q)
      IDLE: begin
        // On a tie the IFU wins only if the LSU held the previous grant.
        grant_ifu = ifu_req_valid && (!lsu_req_valid || (last_grant_q == GRANT_LSU));
        grant_lsu = lsu_req_valid && !grant_ifu;
        if (grant_ifu) begin
          addr_d     = ifu_req_addr;
          wen_d      = 1'b0;
          wdata_d    = '0;
          wmask_d    = '0;
          grant_id_d = GRANT_IFU;
          state_d    = REQ;
        end else if (grant_lsu) begin
          addr_d     = lsu_req_addr;
          wen_d      = lsu_req_wen;
          wdata_d    = lsu_req_wdata;
          wmask_d    = lsu_req_wmask;
          grant_id_d = GRANT_LSU;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (mem_req_ready) state_d = RESP;
      end
      RESP: begin
        if (mem_resp_valid) begin
          last_grant_d = grant_id_q;
          state_d      = IDLE;
          if (grant_id_q == GRANT_IFU) begin
            ifu_resp_valid_d = 1'b1;
            ifu_resp_data_d  = resp_data;
          end else begin
            lsu_resp_valid_d = 1'b1;
            lsu_resp_data_d  = resp_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples its pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      last_grant_q     <= GRANT_LSU;
      grant_id_q       <= GRANT_IFU;
      addr_q           <= '0;
      wen_q            <= 1'b0;
      wdata_q          <= '0;
      wmask_q          <= '0;
      ifu_resp_valid_q <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      ifu_resp_data_q  <= '0;
      lsu_resp_data_q  <= '0;
    end else begin
      state_q          <= state_d;
      last_grant_q     <= last_grant_d;
      grant_id_q       <= grant_id_d;
      addr_q           <= addr_d;
      wen_q            <= wen_d;
      wdata_q          <= wdata_d;
      wmask_q          <= wmask_d;
      ifu_resp_valid_q <= ifu_resp_valid_d;
      lsu_resp_valid_q <= lsu_resp_valid_d;
      ifu_resp_data_q  <= ifu_resp_data_d;
      lsu_resp_data_q  <= lsu_resp_data_d;
    end
  end

  // Ready is combinational from IDLE; it is masked while reset is held so no handshake leaks through.
  assign ifu_req_ready  = grant_ifu && !rst;
  assign lsu_req_ready  = grant_lsu && !rst;
  assign ifu_resp_valid = ifu_resp_valid_q;
  assign ifu_resp_data  = ifu_resp_data_q;
  assign lsu_resp_valid = lsu_resp_valid_q;
  assign lsu_resp_data  = lsu_resp_data_q;
  assign mem_req_valid  = (state_q == REQ);
  assign mem_req_addr   = addr_q;
  assign mem_req_wen    = wen_q;
  assign mem_req_wdata  = wdata_q;
  assign mem_req_wmask  = wmask_q;

endmodule

// File: tb/tb_ysyx_22050612_mem_arbiter.sv
// Scoreboard bench for the IFU/LSU memory arbiter: drivers push expectations at handshake,
// a memory model and a response monitor pop and compare independently.
module tb_ysyx_22050612_mem_arbiter;

  localparam int ADDR_W     = 64;
  localparam int DATA_W     = 64;
  localparam int MASK_W     = DATA_W / 8;
  localparam int RESP_TOTAL = 17;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [ADDR_W-1:0] ifu_req_addr;
  logic [DATA_W-1:0] ifu_resp_data;
  logic              lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_resp_valid;
  logic [ADDR_W-1:0] lsu_req_addr;
  logic [DATA_W-1:0] lsu_req_wdata, lsu_resp_data;
  logic [MASK_W-1:0] lsu_req_wmask;
  logic              mem_req_valid, mem_req_ready, mem_req_wen, mem_resp_valid;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata, mem_resp_data;
  logic [MASK_W-1:0] mem_req_wmask;

  ysyx_22050612_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              is_lsu;
    logic [DATA_W-1:0] data;
  } resp_t;

  typedef struct {
    logic              is_lsu;
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } mreq_t;

  resp_t exp_resp[$];
  mreq_t exp_mreq[$];

  int tests_run    = 0;
  int tests_failed = 0;
  int outstanding  = 0;
  int resp_seen    = 0;
  logic last_is_lsu = 1'b1;

  int req_stall   = 0;
  int resp_stall  = 0;
  bit spur_in_req = 1'b0;
  bit idle_spur   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mem_data(input logic [ADDR_W-1:0] addr);
    case (addr)
      64'h8000_0000: return 64'h0000_0013_0000_0413;
      64'h8000_0008: return 64'h0123_4567_89ab_cdef;
      default:       return {addr[31:0], ~addr[31:0]};
    endcase
  endfunction

  task automatic push_exp(input logic is_lsu, input logic [ADDR_W-1:0] addr, input logic wen,
                          input logic [DATA_W-1:0] wdata, input logic [MASK_W-1:0] wmask);
    mreq_t m;
    resp_t r;
    m.is_lsu = is_lsu; m.addr = addr; m.wen = wen; m.wdata = wdata; m.wmask = wmask;
    r.is_lsu = is_lsu;
    r.data   = wen ? '0 : mem_data(addr);
    exp_mreq.push_back(m);
    exp_resp.push_back(r);
  endtask

  task automatic ifu_read(input logic [ADDR_W-1:0] addr);
    bit done = 1'b0;
    ifu_req_valid = 1'b1;
    ifu_req_addr  = addr;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (ifu_req_ready) begin
        done = 1'b1;
        push_exp(1'b0, addr, 1'b0, '0, '0);
      end
    end
    check("ifu_handshake", 64'(done), 64'd1);
    @(posedge clk); #1;
    ifu_req_valid = 1'b0;
  endtask

  task automatic lsu_access(input logic [ADDR_W-1:0] addr, input logic wen,
                            input logic [DATA_W-1:0] wdata, input logic [MASK_W-1:0] wmask);
    bit done = 1'b0;
    lsu_req_valid = 1'b1;
    lsu_req_addr  = addr;
    lsu_req_wen   = wen;
    lsu_req_wdata = wdata;
    lsu_req_wmask = wmask;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (lsu_req_ready) begin
        done = 1'b1;
        push_exp(1'b1, addr, wen, wdata, wmask);
      end
    end
    check("lsu_handshake", 64'(done), 64'd1);
    @(posedge clk); #1;
    lsu_req_valid = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ctl"}, {58'b0, ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid,
                           mem_req_valid, mem_req_wen}, 64'd0);
    check({name, "_addr"}, mem_req_addr, 64'd0);
    check({name, "_data"}, mem_req_wdata | ifu_resp_data | lsu_resp_data | {56'b0, mem_req_wmask}, 64'd0);
  endtask

  task automatic resp_pop(input logic is_lsu, input logic [DATA_W-1:0] data);
    resp_t r;
    resp_seen++;
    outstanding--;
    if (exp_resp.size() == 0) begin
      check(is_lsu ? "lsu_resp_unexpected" : "ifu_resp_unexpected", 64'd1, 64'd0);
    end else begin
      r = exp_resp.pop_front();
      check("resp_side", 64'(is_lsu), 64'(r.is_lsu));
      check(is_lsu ? "lsu_resp_data" : "ifu_resp_data", data, r.data);
    end
  endtask

  // Response monitor plus grant-order model (round robin, one outstanding).
  always @(negedge clk) begin
    if (rst) begin
      outstanding = 0;
      last_is_lsu = 1'b1;
      exp_resp.delete();
    end else begin
      if (ifu_resp_valid) resp_pop(1'b0, ifu_resp_data);
      if (lsu_resp_valid) resp_pop(1'b1, lsu_resp_data);
      if (ifu_req_ready || lsu_req_ready) begin
        check("grant_while_busy", 64'(outstanding), 64'd0);
        check("grant_both", 64'(ifu_req_ready && lsu_req_ready), 64'd0);
        check("grant_with_mem_valid", 64'(mem_req_valid), 64'd0);
        if (ifu_req_valid && lsu_req_valid)
          check("round_robin", 64'(lsu_req_ready), 64'(!last_is_lsu));
        else
          check("ready_without_valid", 64'((ifu_req_ready && !ifu_req_valid) ||
                                           (lsu_req_ready && !lsu_req_valid)), 64'd0);
        last_is_lsu = lsu_req_ready;
        outstanding++;
      end
    end
  end

  // Memory model: checks each issued request, applies stalls, returns data.
  initial begin
    mreq_t e;
    bit    dropped;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    forever begin
      @(posedge clk); #1;
      mem_req_ready  = idle_spur;
      mem_resp_valid = idle_spur;
      if (mem_req_valid && !rst) begin
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        dropped        = 1'b0;
        if (exp_mreq.size() == 0) begin
          check("mem_req_unexpected", 64'd1, 64'd0);
          e = '{is_lsu: 1'b0, addr: '0, wen: 1'b0, wdata: '0, wmask: '0};
        end else begin
          e = exp_mreq.pop_front();
        end
        check("mem_req_addr", mem_req_addr, e.addr);
        check("mem_req_wen", 64'(mem_req_wen), 64'(e.wen));
        check("mem_req_wdata", mem_req_wdata, e.wdata);
        check("mem_req_wmask", 64'(mem_req_wmask), 64'(e.wmask));
        for (int i = 0; i < req_stall; i++) begin
          mem_resp_valid = spur_in_req;
          @(posedge clk); #1;
          check("mem_req_stable", {59'b0, mem_req_valid, mem_req_addr == e.addr, mem_req_wen == e.wen,
                                   mem_req_wdata == e.wdata, mem_req_wmask == e.wmask}, 64'h1f);
        end
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        check("mem_req_valid_in_resp", 64'(mem_req_valid), 64'd0);
        for (int i = 0; i < resp_stall; i++) begin
          dropped |= rst;
          @(posedge clk); #1;
        end
        dropped |= rst;
        mem_resp_valid = 1'b1;
        mem_resp_data  = e.wen ? '1 : mem_data(e.addr);
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        if (dropped)
          check("drop_no_resp", 64'(ifu_resp_valid || lsu_resp_valid), 64'd0);
        else
          check("resp_latency", 64'(e.is_lsu ? lsu_resp_valid : ifu_resp_valid), 64'd1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  initial begin
    ifu_req_valid = 1'b0; ifu_req_addr = '0;
    lsu_req_valid = 1'b0; lsu_req_addr = '0; lsu_req_wen = 1'b0;
    lsu_req_wdata = '0;   lsu_req_wmask = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_reset");

    // Single zero-wait IFU fetch with exact cycle latency.
    @(posedge clk); #1;
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 64'h8000_0000;
    @(negedge clk);
    check("t1_ifu_ready", 64'(ifu_req_ready), 64'd1);
    check("t1_lsu_ready", 64'(lsu_req_ready), 64'd0);
    push_exp(1'b0, 64'h8000_0000, 1'b0, '0, '0);
    @(posedge clk); #1;
    ifu_req_valid = 1'b0;
    @(negedge clk);
    check("t1_mem_valid", 64'(mem_req_valid), 64'd1);
    check("t1_mem_addr", mem_req_addr, 64'h8000_0000);
    @(negedge clk);
    check("t1_no_early_resp", 64'(ifu_resp_valid), 64'd0);
    @(negedge clk);
    check("t1_resp_valid", 64'(ifu_resp_valid), 64'd1);
    check("t1_resp_data", ifu_resp_data, 64'h0000_0013_0000_0413);
    settle(2);

    // Reset in IDLE, then contending requesters alternate for 10 transactions.
    @(posedge clk); #2; rst = 1'b1;
    @(posedge clk); #2; rst = 1'b0;
    @(posedge clk); #1;
    fork
      begin
        ifu_read(64'h8000_0000);
        ifu_read(64'h8000_0010);
        ifu_read(64'h8000_0018);
        ifu_read(64'h8000_0020);
        ifu_read(64'h8000_0028);
      end
      begin
        lsu_access(64'h8000_1004, 1'b1, 64'hdead_beef_0000_0000, 8'hf0);
        lsu_access(64'h8000_0008, 1'b0, '0, '0);
        lsu_access(64'h8000_1010, 1'b1, 64'h1122_3344_5566_7788, 8'hff);
        lsu_access(64'h8000_0100, 1'b0, '0, '0);
        lsu_access(64'h8000_1008, 1'b1, 64'h0000_0000_0000_00a5, 8'h01);
      end
    join
    settle(6);

    // Memory stalls with a second requester waiting.
    req_stall  = 4;
    resp_stall = 5;
    fork
      ifu_read(64'h8000_0030);
      lsu_access(64'h8000_1020, 1'b1, 64'hcafe_f00d_1234_5678, 8'h0f);
    join
    settle(25);
    req_stall  = 0;
    resp_stall = 0;

    // LSU read with the IFU arriving mid-transaction.
    fork
      lsu_access(64'h8000_0008, 1'b0, '0, '0);
      begin
        settle(2);
        ifu_read(64'h8000_0040);
      end
    join
    settle(6);

    // Reset while in RESP, late memory response the following cycle.
    resp_stall = 1;
    ifu_read(64'h8000_0048);
    @(posedge clk); #2;
    rst = 1'b1;
    @(negedge clk);
    check("t5_in_resp", 64'(mem_req_valid), 64'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("t5_after_rst");
    settle(4);
    resp_stall = 0;
    ifu_read(64'h8000_0050);
    settle(6);

    // Spurious memory strobes in IDLE and in REQ.
    idle_spur = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_idle_spurious", 64'({mem_req_valid, ifu_resp_valid, lsu_resp_valid}), 64'd0);
    end
    @(posedge clk); #1;
    idle_spur = 1'b0;
    settle(2);
    req_stall   = 3;
    spur_in_req = 1'b1;
    ifu_read(64'h8000_0058);
    settle(12);
    req_stall   = 0;
    spur_in_req = 1'b0;

    check("resp_queue_drained", 64'(exp_resp.size()), 64'd0);
    check("mreq_queue_drained", 64'(exp_mreq.size()), 64'd0);
    check("resp_count", 64'(resp_seen), 64'(RESP_TOTAL));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ysyx_22050612_mem_arbiter.md
# ysyx_22050612_mem_arbiter

Two-requester arbiter and sequencer for the single shared memory port. The IFU (instruction fetch, read-only) and the LSU (loads/stores issued by the EXU) each present a request with a valid/ready handshake. The block grants one at a time, drives the shared memory request channel, and routes the response back to the granted requester. Exactly one transaction is outstanding at any time; it replaces direct per-unit `pmem_read`/`pmem_write` access.

## Interface
Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data width; wmask width is DATA_W/8

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- ifu_req_valid  in  1  IFU read request pending
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_req_addr  in  ADDR_W  fetch address
- ifu_resp_valid  out  1  one-cycle pulse: ifu_resp_data valid
- ifu_resp_data  out  DATA_W  fetched data
- lsu_req_valid  in  1  LSU request pending
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_req_addr  in  ADDR_W  access address
- lsu_req_wen  in  1  1 = write, 0 = read
- lsu_req_wdata  in  DATA_W  write data, lane-aligned
- lsu_req_wmask  in  DATA_W/8  byte enables
- lsu_resp_valid  out  1  one-cycle pulse: read data or write ack
- lsu_resp_data  out  DATA_W  read data; 0 for writes
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_W  latched address
- mem_req_wen  out  1  latched write flag
- mem_req_wdata  out  DATA_W  latched write data
- mem_req_wmask  out  DATA_W/8  latched mask
- mem_resp_valid  in  1  memory response/ack
- mem_resp_data  in  DATA_W  memory read data

## Operation
- States: IDLE, REQ, RESP.
- IDLE: if exactly one requester is valid, it is granted. If both are valid, grant goes to the requester not granted last (round-robin via register last_grant). The granted `*_req_ready` is driven high combinationally in the same cycle. The request fields are latched, plus grant_id. Next state is REQ. With no requester valid, stay in IDLE.
- Only the granted requester sees ready; the other ready stays 0.
- REQ: mem_req_valid=1, and mem_req_* are driven from the latched fields. They must stay stable until mem_req_ready=1, then go to RESP.
- RESP: mem_req_valid=0. Wait for mem_resp_valid=1. Then register the response into the granted requester: its resp_valid pulses the next cycle with data = mem_resp_data (reads) or 0 (writes). Update last_grant and return to IDLE.
- IFU requests: latched wen=0, wmask=0, wdata=0.
- mem_resp_valid outside RESP is ignored.
- mem_req_ready outside REQ is ignored.
- No response backpressure: requesters must accept a resp_valid pulse whenever it is issued.

## Timing
- Reset values:
  - State = IDLE; last_grant = LSU, so the first tie goes to the IFU.
  - All `*_req_ready`, `*_resp_valid` and mem_req_valid = 0.
  - All data/addr/mask outputs = 0.
- Best-case latency:
  - Handshake at cycle N.
  - mem_req_valid at N+1; with mem_req_ready=1 at N+1, state is RESP at N+2.
  - mem_resp_valid at N+2 gives `*_resp_valid` at N+3.
- Back-to-back: in the cycle `*_resp_valid` pulses, the state is already IDLE, so a new grant can handshake in that same cycle. Peak throughput is one transaction per 3 cycles.
- Memory stalls: each mem_req_ready=0 cycle in REQ and each mem_resp_valid=0 cycle in RESP adds one cycle. There is no timeout.
- Reset mid-operation (REQ or RESP): the next cycle is IDLE with all outputs at reset values. The in-flight transaction is dropped, no resp_valid is emitted, and a late mem_resp_valid is ignored.
- A requester dropping valid before ready is legal. It is simply not granted, and no state changes for it.

## Test plan
- Reset, then IFU-only read addr 0x80000000, memory zero-wait with data 0x00000013_00000413 -> ifu_req_ready at N, mem_req_valid/addr 0x80000000 at N+1, ifu_resp_valid + data at N+3; lsu_resp_valid never asserts.
- Simultaneous IFU read and LSU write (addr 0x80001004, wdata 0xdeadbeef00000000, wmask 0xF0) held valid -> IFU granted first. The LSU write is then issued with mem_req_wen=1, wmask 0xF0, after which lsu_resp_valid pulses with data 0. Grants alternate IFU/LSU for 8 more transactions.
- Memory holds mem_req_ready=0 for 4 cycles and delays mem_resp_valid 5 cycles -> mem_req_* stable throughout REQ, resp_valid exactly one cycle after mem_resp_valid, no new grant before it.
- LSU read addr 0x80000008 while IFU valid mid-transaction -> IFU ready stays 0 until IDLE; LSU resp_data equals memory data 0x0123456789abcdef.
- Assert rst in RESP, then drive mem_resp_valid the following cycle -> no resp_valid on either side; all outputs 0; next IFU request handshakes normally.
- Spurious mem_resp_valid in IDLE and REQ -> ignored, no resp_valid, no state change.
